// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous memory between the CPU data port (D)
//   and the instruction-fetch / loader port (I). Round-robin arbitration,
//   at most one access issued per cycle, and read responses routed back in
//   issue order through a RD_LAT-deep {valid, owner} pipeline.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   d_req/d_we/d_addr/d_wdata  D request (held until d_gnt)
//   d_gnt, d_rvalid            D issue strobe (comb), D read response (reg)
//   i_req/i_we/i_addr/i_wdata  I request (held until i_gnt)
//   i_gnt, i_rvalid            I issue strobe (comb), I read response (reg)
//   rdata                      shared read data, qualified by d/i_rvalid
//   mem_address/mem_write/
//   mem_writedata              memory command side
//   mem_readword               memory read data, RD_LAT cycles after issue
module mem_port_arbiter #(
  parameter int AW     = 10,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  input  logic          i_req,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_address,
  output logic          mem_write,
  output logic [DW-1:0] mem_writedata,
  input  logic [DW-1:0] mem_readword
);

  generate
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
      $error("mem_port_arbiter: RD_LAT must be in 1..4");
    end
  endgenerate

  logic              r_last_gnt;   // 0 = D granted last, 1 = I granted last
  logic [AW-1:0]     r_addr;       // last issued address, held while idle
  logic [DW-1:0]     r_wdata;      // last issued write data, held while idle
  logic [RD_LAT-1:0] r_vld_pipe;   // read in flight per stage
  logic [RD_LAT-1:0] r_own_pipe;   // owner per stage: 0 = D, 1 = I

  logic w_d_gnt;
  logic w_i_gnt;
  logic w_rd_issue;

  // D wins when alone or when I was granted last; I takes whatever D does not.
  always_comb begin
    w_d_gnt = !rst && d_req && (!i_req || r_last_gnt);
    w_i_gnt = !rst && i_req && !w_d_gnt;
  end

  always_comb begin
    mem_address   = r_addr;
    mem_writedata = r_wdata;
    mem_write     = 1'b0;
    w_rd_issue    = 1'b0;
    if (w_d_gnt) begin
      mem_address   = d_addr;
      mem_writedata = d_wdata;
      mem_write     = d_we;
      w_rd_issue    = !d_we;
    end else if (w_i_gnt) begin
      mem_address   = i_addr;
      mem_writedata = i_wdata;
      mem_write     = i_we;
      w_rd_issue    = !i_we;
    end
  end

  assign d_gnt = w_d_gnt;
  assign i_gnt = w_i_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_gnt <= 1'b1;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_vld_pipe <= '0;
      r_own_pipe <= '0;
      d_rvalid   <= 1'b0;
      i_rvalid   <= 1'b0;
      rdata      <= '0;
    end else begin
      if (w_d_gnt || w_i_gnt) begin
        r_last_gnt <= w_i_gnt;
        r_addr     <= mem_address;
        r_wdata    <= mem_writedata;
      end
      r_vld_pipe[0] <= w_rd_issue;
      r_own_pipe[0] <= w_i_gnt;
      for (int s = 1; s < RD_LAT; s++) begin
        r_vld_pipe[s] <= r_vld_pipe[s-1];
        r_own_pipe[s] <= r_own_pipe[s-1];
      end
      // The last stage lines up with mem_readword; register data and strobe
      // together so the requester sees them aligned one cycle later.
      d_rvalid <= r_vld_pipe[RD_LAT-1] && !r_own_pipe[RD_LAT-1];
      i_rvalid <= r_vld_pipe[RD_LAT-1] &&  r_own_pipe[RD_LAT-1];
      if (r_vld_pipe[RD_LAT-1])
        rdata <= mem_readword;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Two instances share the same
// stimulus: u_dut1 (RD_LAT=1) and u_dut3 (RD_LAT=3), each backed by its own
// behavioural memory with the matching read latency.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        load;
  logic        d_req, d_we, i_req, i_we;
  logic [9:0]  d_addr, i_addr;
  logic [31:0] d_wdata, i_wdata;

  logic        d_gnt, i_gnt, d_rvalid, i_rvalid, mw1;
  logic [31:0] rdata, mwd1, mrw1;
  logic [9:0]  ma1;
  logic        d3_gnt, i3_gnt, d3_rvalid, i3_rvalid, mw3;
  logic [31:0] rdata3, mwd3, mrw3;
  logic [9:0]  ma3;

  logic [31:0] mem1 [0:1023];
  logic [31:0] mem3 [0:1023];
  logic [31:0] rd3  [0:2];

  int n_cmp;
  int n_err;

  mem_port_arbiter #(.AW(10), .DW(32), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .rdata(rdata), .mem_address(ma1), .mem_write(mw1),
    .mem_writedata(mwd1), .mem_readword(mrw1)
  );

  mem_port_arbiter #(.AW(10), .DW(32), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d3_gnt), .d_rvalid(d3_rvalid),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_gnt(i3_gnt), .i_rvalid(i3_rvalid),
    .rdata(rdata3), .mem_address(ma3), .mem_write(mw3),
    .mem_writedata(mwd3), .mem_readword(mrw3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memories: load contents while 'load' is high, otherwise a
  // single port with registered read (1 stage for dut1, 3 stages for dut3).
  always @(posedge clk) begin
    if (load) begin
      for (int a = 0; a < 1024; a++) begin
        mem1[a] <= 32'h0;
        mem3[a] <= 32'h0;
      end
      mem1[10'h001] <= 32'h1111_0001; mem3[10'h001] <= 32'h1111_0001;
      mem1[10'h002] <= 32'h2222_0002; mem3[10'h002] <= 32'h2222_0002;
      mem1[10'h004] <= 32'h0000_0013; mem3[10'h004] <= 32'h0000_0013;
      mem1[10'h010] <= 32'hA0A0_0010; mem3[10'h010] <= 32'hA0A0_0010;
      mem1[10'h011] <= 32'hA0A0_0011; mem3[10'h011] <= 32'hA0A0_0011;
      mem1[10'h012] <= 32'hA0A0_0012; mem3[10'h012] <= 32'hA0A0_0012;
    end else begin
      if (mw1) mem1[ma1] <= mwd1;
      if (mw3) mem3[ma3] <= mwd3;
    end
    mrw1   <= mem1[ma1];
    rd3[0] <= mem3[ma3];
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end
  assign mrw3 = rd3[2];

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    load = 1'b0;
    d_req = 1; d_we = 1; d_addr = 10'h155; d_wdata = 32'h1234_5678;
    i_req = 1; i_we = 1; i_addr = 10'h0AA; i_wdata = 32'h8765_4321;
    #1;
    n_cmp++; if (d_gnt !== 1'b0) begin n_err++; $display("FAIL rst_d_gnt got=%0h exp=0", d_gnt); end
    n_cmp++; if (i_gnt !== 1'b0) begin n_err++; $display("FAIL rst_i_gnt got=%0h exp=0", i_gnt); end
    n_cmp++; if (mw1 !== 1'b0) begin n_err++; $display("FAIL rst_mem_write got=%0h exp=0", mw1); end
    @(negedge clk);
    n_cmp++; if (d_rvalid !== 1'b0 || i_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_rvalid got=%0h%0h exp=00", d_rvalid, i_rvalid); end
    n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata got=%h exp=00000000", rdata); end
    n_cmp++; if (ma1 !== 10'h0) begin n_err++; $display("FAIL rst_mem_address got=%h exp=000", ma1); end
    n_cmp++; if (mwd1 !== 32'h0) begin n_err++; $display("FAIL rst_mem_writedata got=%h exp=00000000", mwd1); end
    d_req = 0; i_req = 0; d_we = 0; i_we = 0;
    rst = 1'b0;
  endtask

  task automatic test_alternate;
    logic exp_d;
    idle(2);
    @(negedge clk);
    d_req = 1; d_we = 0; d_addr = 10'h004;
    i_req = 1; i_we = 0; i_addr = 10'h010;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_d = (k % 2 == 0);
      n_cmp++; if (d_gnt !== exp_d || i_gnt !== !exp_d) begin n_err++; $display("FAIL alt_gnt[%0d] got d=%0h i=%0h exp d=%0h i=%0h", k, d_gnt, i_gnt, exp_d, !exp_d); end
      n_cmp++; if (mw1 !== 1'b0) begin n_err++; $display("FAIL alt_mem_write[%0d] got=%0h exp=0", k, mw1); end
      n_cmp++; if (ma1 !== (exp_d ? 10'h004 : 10'h010)) begin n_err++; $display("FAIL alt_mem_address[%0d] got=%h exp=%h", k, ma1, exp_d ? 10'h004 : 10'h010); end
      @(negedge clk);
    end
    d_req = 0; i_req = 0;
    idle(3);
  endtask

  task automatic test_single_read;
    idle(2);
    @(negedge clk);
    d_req = 1; d_we = 0; d_addr = 10'h004;
    #1;
    n_cmp++; if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin n_err++; $display("FAIL rd_gnt got d=%0h i=%0h exp d=1 i=0", d_gnt, i_gnt); end
    n_cmp++; if (ma1 !== 10'h004 || mw1 !== 1'b0) begin n_err++; $display("FAIL rd_mem_cmd got addr=%h we=%0h exp addr=004 we=0", ma1, mw1); end
    @(negedge clk);
    d_req = 0;
    n_cmp++; if (d_rvalid !== 1'b0 || i_rvalid !== 1'b0) begin n_err++; $display("FAIL rd_early_rvalid got=%0h%0h exp=00", d_rvalid, i_rvalid); end
    @(negedge clk);
    n_cmp++; if (d_rvalid !== 1'b1 || i_rvalid !== 1'b0) begin n_err++; $display("FAIL rd_rvalid got d=%0h i=%0h exp d=1 i=0", d_rvalid, i_rvalid); end
    n_cmp++; if (rdata !== 32'h0000_0013) begin n_err++; $display("FAIL rd_rdata got=%h exp=00000013", rdata); end
    @(negedge clk);
    n_cmp++; if (d_rvalid !== 1'b0 || i_rvalid !== 1'b0) begin n_err++; $display("FAIL rd_rvalid_drop got=%0h%0h exp=00", d_rvalid, i_rvalid); end
  endtask

  task automatic test_write_then_read;
    idle(2);
    @(negedge clk);
    i_req = 1; i_we = 1; i_addr = 10'h3FF; i_wdata = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if (i_gnt !== 1'b1 || mw1 !== 1'b1) begin n_err++; $display("FAIL wr_issue got gnt=%0h we=%0h exp gnt=1 we=1", i_gnt, mw1); end
    n_cmp++; if (ma1 !== 10'h3FF || mwd1 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_cmd got addr=%h data=%h exp addr=3ff data=deadbeef", ma1, mwd1); end
    @(negedge clk);
    i_req = 0; i_we = 0;
    d_req = 1; d_we = 0; d_addr = 10'h3FF;
    #1;
    n_cmp++; if (d_gnt !== 1'b1 || mw1 !== 1'b0 || ma1 !== 10'h3FF) begin n_err++; $display("FAIL wr_rd_issue got gnt=%0h we=%0h addr=%h exp 1 0 3ff", d_gnt, mw1, ma1); end
    @(negedge clk);
    d_req = 0;
    #1;
    n_cmp++; if (mw1 !== 1'b0 || d_rvalid !== 1'b0) begin n_err++; $display("FAIL wr_idle got we=%0h rvalid=%0h exp 0 0", mw1, d_rvalid); end
    @(negedge clk);
    n_cmp++; if (d_rvalid !== 1'b1 || i_rvalid !== 1'b0 || rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_rd_resp got d=%0h i=%0h data=%h exp 1 0 deadbeef", d_rvalid, i_rvalid, rdata); end
  endtask

  task automatic test_pipelined;
    logic [31:0] exp_data [0:2];
    logic        exp_v;
    exp_data[0] = 32'hA0A0_0010;
    exp_data[1] = 32'hA0A0_0011;
    exp_data[2] = 32'hA0A0_0012;
    idle(6);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k < 3) begin
        i_req = 1; i_we = 0; i_addr = 10'h010 + 10'(k);
      end else begin
        i_req = 0;
      end
      #1;
      if (k < 3) begin
        n_cmp++; if (i3_gnt !== 1'b1) begin n_err++; $display("FAIL pipe_gnt[%0d] got=%0h exp=1", k, i3_gnt); end
      end
      exp_v = (k >= 4 && k <= 6);
      n_cmp++; if (i3_rvalid !== exp_v || d3_rvalid !== 1'b0) begin n_err++; $display("FAIL pipe_rvalid[%0d] got i=%0h d=%0h exp i=%0h d=0", k, i3_rvalid, d3_rvalid, exp_v); end
      if (k >= 4 && k <= 6) begin
        n_cmp++; if (rdata3 !== exp_data[k-4]) begin n_err++; $display("FAIL pipe_rdata[%0d] got=%h exp=%h", k, rdata3, exp_data[k-4]); end
      end
    end
  endtask

  task automatic test_interleaved;
    idle(6);
    @(negedge clk);
    d_req = 1; d_we = 0; d_addr = 10'h001;
    #1;
    n_cmp++; if (d_gnt !== 1'b1) begin n_err++; $display("FAIL il_d_gnt got=%0h exp=1", d_gnt); end
    @(negedge clk);
    d_req = 0;
    i_req = 1; i_we = 0; i_addr = 10'h002;
    #1;
    n_cmp++; if (i_gnt !== 1'b1 || d_gnt !== 1'b0) begin n_err++; $display("FAIL il_i_gnt got i=%0h d=%0h exp i=1 d=0", i_gnt, d_gnt); end
    n_cmp++; if (d_rvalid !== 1'b0 || i_rvalid !== 1'b0) begin n_err++; $display("FAIL il_early got=%0h%0h exp=00", d_rvalid, i_rvalid); end
    @(negedge clk);
    i_req = 0;
    n_cmp++; if (d_rvalid !== 1'b1 || i_rvalid !== 1'b0 || rdata !== 32'h1111_0001) begin n_err++; $display("FAIL il_d_resp got d=%0h i=%0h data=%h exp 1 0 11110001", d_rvalid, i_rvalid, rdata); end
    @(negedge clk);
    n_cmp++; if (d_rvalid !== 1'b0 || i_rvalid !== 1'b1 || rdata !== 32'h2222_0002) begin n_err++; $display("FAIL il_i_resp got d=%0h i=%0h data=%h exp 0 1 22220002", d_rvalid, i_rvalid, rdata); end
    @(negedge clk);
    n_cmp++; if (d_rvalid !== 1'b0 || i_rvalid !== 1'b0) begin n_err++; $display("FAIL il_drain got=%0h%0h exp=00", d_rvalid, i_rvalid); end
  endtask

  task automatic test_reset_midflight;
    idle(6);
    @(negedge clk);
    d_req = 1; d_we = 0; d_addr = 10'h004;
    #1;
    n_cmp++; if (d_gnt !== 1'b1) begin n_err++; $display("FAIL mf_d_gnt got=%0h exp=1", d_gnt); end
    @(negedge clk);
    d_req = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (d_rvalid !== 1'b0 || i_rvalid !== 1'b0) begin n_err++; $display("FAIL mf_rvalid got=%0h%0h exp=00", d_rvalid, i_rvalid); end
    n_cmp++; if (rdata !== 32'h0 || ma1 !== 10'h0) begin n_err++; $display("FAIL mf_cleared got data=%h addr=%h exp 00000000 000", rdata, ma1); end
    d_req = 1; d_we = 0; d_addr = 10'h001;
    i_req = 1; i_we = 0; i_addr = 10'h002;
    #1;
    n_cmp++; if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin n_err++; $display("FAIL mf_conflict got d=%0h i=%0h exp d=1 i=0", d_gnt, i_gnt); end
    @(negedge clk);
    d_req = 0; i_req = 0;
    n_cmp++; if (d_rvalid !== 1'b0) begin n_err++; $display("FAIL mf_no_resp got=%0h exp=0", d_rvalid); end
    @(negedge clk);
    n_cmp++; if (d_rvalid !== 1'b1 || rdata !== 32'h1111_0001) begin n_err++; $display("FAIL mf_post_resp got v=%0h data=%h exp 1 11110001", d_rvalid, rdata); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; load = 1'b1;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    i_req = 0; i_we = 0; i_addr = '0; i_wdata = '0;
    test_reset;
    test_alternate;
    test_single_read;
    test_write_then_read;
    test_pipelined;
    test_interleaved;
    test_reset_midflight;
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
